fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
- Parametrised single-clock FIFO; next generation of the team's fixed 32-bit FIFO.
- Adds configurable width and depth, and an occupancy count.
- Adds programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer datapath stages; drop-in where the old FIFO used clk/rst/rd/wr/empty/full/data_in/data_out.

Parameters:
- DATA_WIDTH, 32, bits per word.
- DEPTH, 16, number of entries; any integer >= 2 (not restricted to powers of two).
- AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL.
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low; sampled on rising clk edge.
- wr  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- rd  in  1  read request (pop).
- data_out  out  DATA_WIDTH  read data.
- empty  out  1  FIFO holds 0 entries.
- full  out  1  FIFO holds DEPTH entries.
- almost_empty  out  1  count <= AE_LEVEL.
- almost_full  out  1  count >= AF_LEVEL.
- count  out  CW=$clog2(DEPTH+1)  current occupancy.
- err_clr  in  1  clears the sticky error flags.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rst==0 at a clk edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0).
  - overflow=0, underflow=0, data_out=0.
  - Memory contents are not cleared.
  - Reset overrides all other inputs in the same cycle, including mid-burst traffic.
- Acceptance, evaluated on the current-cycle registered state:
  - rd_acc = rd & ~empty.
  - wr_acc = wr & (~full | rd_acc): a write while full succeeds if a read is accepted in the same cycle.
- Update on each clk edge:
  - count_next = count + wr_acc - rd_acc.
  - Pointers advance by 1 on acceptance and wrap from DEPTH-1 to 0 by explicit compare, not modulo-2^n.
  - Write stores data_in at wr_ptr.
- Simultaneous rd & wr:
  - When empty: the write is accepted, the read is rejected, and underflow is set.
  - When full: both are accepted, count stays at DEPTH, and overflow is not set.
- Error flags:
  - overflow is set on wr & ~wr_acc; underflow is set on rd & ~rd_acc.
  - Both hold until err_clr=1 or reset.
  - If err_clr and a new error occur in the same cycle, the set wins.
- Status flags (empty, full, almost_*, count) are all registered and change on the edge after the causing access. Latency: a write becomes visible in count/empty 1 cycle later.
- Standard mode (FWFT=0):
  - data_out is registered and loaded with mem[rd_ptr] on the edge where rd_acc=1, so data is valid the cycle after rd.
  - data_out holds its value otherwise, including after empty is reached.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] whenever ~empty, so the head word is valid in the same cycle empty deasserts.
  - rd pops the word to expose the next one.
  - data_out = 0 while empty.
- The ordering guarantee is strict FIFO; no data is lost or reordered across pointer wrap.
- Illegal parameters (DEPTH<2, AF_LEVEL>DEPTH, AE_LEVEL>=DEPTH) are caught by an elaboration-time check that stops the build.

Decomposition:
- Shared package fifo_pkg holds:
  - the CW width function (clog2 of DEPTH+1);
  - the FWFT mode constants FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1.
- One sub-module: fifo_ram_sp, a simple dual-port register array (one write port, one asynchronous read address) of DATA_WIDTH x DEPTH.
- Pointer, count, flag and mode logic stay in fifo_sync_param.

Test Plan:
1. Reset then basic ordering (FWFT=0, DEPTH=4):
   - Stimulus: write 0x10, 0x20, 0x30, 0x40; then rd x4.
   - Expect: full=1 after the 4th write, count=4, almost_full=1; data_out 0x10, 0x20, 0x30, 0x40 each 1 cycle after rd; empty=1 at end; no error flags.
2. Overflow:
   - Stimulus: with DEPTH=4 full, wr=1 data 0x50 with rd=0.
   - Expect: count stays 4, overflow=1 and stays 1 until err_clr pulse, then 0; a later read returns 0x10, not 0x50.
3. Underflow and empty simultaneous access:
   - Stimulus: from empty, rd=1 & wr=1 with 0xAA.
   - Expect: underflow=1, count=1, empty=0 next cycle; next rd returns 0xAA.
4. Full simultaneous access plus wrap:
   - Stimulus: fill DEPTH=5 (non-power-of-two) with 1..5; pulse rd&wr with 6 for 3 cycles; drain.
   - Expect: count stays 5 throughout; output sequence 1..8 (writes 6, 7, 8) with correct pointer wrap; no overflow.
5. FWFT mode:
   - Stimulus: FWFT=1, write 0x11.
   - Expect: data_out=0x11 on the cycle empty goes 0, before any rd; rd pops and data_out=0 when empty again.
   - Also: AE_LEVEL=1 gives almost_empty toggling at count=1→2.
6. Reset mid-operation:
   - Stimulus: with count=3, assert rst=0 for one cycle during wr=1.
   - Expect: count=0, empty=1, overflow=underflow=0, data_out=0 the following cycle; the write in the reset cycle is discarded.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO family:
// count-width helper and read-mode selector constants.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int fifo_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ram_sp.sv
// Register-array storage for the FIFO: one synchronous write port and
// one asynchronous read address.
module fifo_ram_sp #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Storage write; contents are intentionally never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty flags, sticky error flags and optional FWFT read.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  DEPTH      = 16,
    parameter int  AF_LEVEL   = DEPTH - 2,
    parameter int  AE_LEVEL   = 2,
    parameter int  FWFT       = FIFO_MODE_STD,
    localparam int CW         = fifo_cw(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [CW-1:0]         count,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_LAST_C = AW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C       = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C       = CW'(AE_LEVEL);

    if (DEPTH < 2 || AF_LEVEL > DEPTH || AF_LEVEL < 0 || AE_LEVEL >= DEPTH ||
        AE_LEVEL < 0 || (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT)) begin : g_bad_params
        $fatal(1, "fifo_sync_param: illegal DEPTH/AF_LEVEL/AE_LEVEL/FWFT combination");
    end

    logic [AW-1:0]         wr_ptr_r, rd_ptr_r;
    logic [AW-1:0]         wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [CW-1:0]         count_r, count_nxt_s;
    logic                  empty_r, full_r, ae_r, af_r;
    logic                  overflow_r, underflow_r;
    logic                  rd_acc_s, wr_acc_s;
    logic [DATA_WIDTH-1:0] ram_rdata_s;

    fifo_ram_sp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc_s),
        .waddr (wr_ptr_r),
        .wdata (data_in),
        .raddr (rd_ptr_r),
        .rdata (ram_rdata_s)
    );

    // Acceptance: a write into a full FIFO is allowed when a read frees a slot.
    always_comb begin
        rd_acc_s = rd & ~empty_r;
        wr_acc_s = wr & (~full_r | rd_acc_s);
    end

    // Next pointers (explicit wrap so any DEPTH works) and next occupancy.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (wr_acc_s) begin
            if (wr_ptr_r == PTR_LAST_C) begin
                wr_ptr_nxt_s = '0;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r + AW'(1);
            end
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (rd_acc_s) begin
            if (rd_ptr_r == PTR_LAST_C) begin
                rd_ptr_nxt_s = '0;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r + AW'(1);
            end
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer, occupancy, status and sticky error registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            empty_r     <= 1'b1;
            full_r      <= 1'b0;
            ae_r        <= 1'b1;
            af_r        <= (AF_LEVEL == 0);
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            empty_r     <= (count_nxt_s == '0);
            full_r      <= (count_nxt_s == DEPTH_C);
            ae_r        <= (count_nxt_s <= AE_C);
            af_r        <= (count_nxt_s >= AF_C);
            // A new error in the same cycle as err_clr keeps the flag set.
            overflow_r  <= (wr & ~wr_acc_s) | (overflow_r & ~err_clr);
            underflow_r <= (rd & ~rd_acc_s) | (underflow_r & ~err_clr);
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is exposed directly from storage while non-empty.
        assign data_out = empty_r ? '0 : ram_rdata_s;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_r;

        // Registered read data, loaded only on an accepted pop.
        always_ff @(posedge clk) begin
            if (!rst) begin
                dout_r <= '0;
            end else if (rd_acc_s) begin
                dout_r <= ram_rdata_s;
            end else begin
                dout_r <= dout_r;
            end
        end

        assign data_out = dout_r;
    end

    assign count        = count_r;
    assign empty        = empty_r;
    assign full         = full_r;
    assign almost_empty = ae_r;
    assign almost_full  = af_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Three FIFO configurations (DEPTH=4 std, DEPTH=5 std, DEPTH=4 FWFT AE=1)
// share one stimulus stream; each is compared against an unbounded-log model.
module tb_fifo_sync_param;

    logic       clk;
    logic       rst;
    logic       wr;
    logic       rd;
    logic       err_clr;
    logic [7:0] data_in;

    logic [7:0] dout_w [3];
    logic [2:0] cnt_w  [3];
    logic       emp_w  [3];
    logic       ful_w  [3];
    logic       ae_w   [3];
    logic       af_w   [3];
    logic       ovf_w  [3];
    logic       unf_w  [3];

    int checks = 0;
    int errors = 0;

    // Model: every accepted word is appended to a per-config log; the
    // occupancy is writes minus reads, the head is log[reads].
    int         m_depth [3] = '{4, 5, 4};
    int         m_af    [3] = '{2, 3, 2};
    int         m_ae    [3] = '{2, 2, 1};
    int         m_fwft  [3] = '{0, 0, 1};
    logic [7:0] hist    [3][1024];
    int         wcnt    [3];
    int         rcnt    [3];
    logic       m_ovf   [3];
    logic       m_unf   [3];
    logic [7:0] m_dout  [3];

    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .wr(wr), .data_in(data_in), .rd(rd),
        .data_out(dout_w[0]), .empty(emp_w[0]), .full(ful_w[0]),
        .almost_empty(ae_w[0]), .almost_full(af_w[0]), .count(cnt_w[0]),
        .err_clr(err_clr), .overflow(ovf_w[0]), .underflow(unf_w[0])
    );

    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(5)) u1 (
        .clk(clk), .rst(rst), .wr(wr), .data_in(data_in), .rd(rd),
        .data_out(dout_w[1]), .empty(emp_w[1]), .full(ful_w[1]),
        .almost_empty(ae_w[1]), .almost_full(af_w[1]), .count(cnt_w[1]),
        .err_clr(err_clr), .overflow(ovf_w[1]), .underflow(unf_w[1])
    );

    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(4), .AE_LEVEL(1), .FWFT(1)) u2 (
        .clk(clk), .rst(rst), .wr(wr), .data_in(data_in), .rd(rd),
        .data_out(dout_w[2]), .empty(emp_w[2]), .full(ful_w[2]),
        .almost_empty(ae_w[2]), .almost_full(af_w[2]), .count(cnt_w[2]),
        .err_clr(err_clr), .overflow(ovf_w[2]), .underflow(unf_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input int i, input logic rstv, input logic wrv,
                                input logic rdv, input logic clrv, input logic [7:0] dv);
        int   occ;
        logic racc;
        logic wacc;
        occ = wcnt[i] - rcnt[i];
        if (!rstv) begin
            wcnt[i]   = 0;
            rcnt[i]   = 0;
            m_ovf[i]  = 1'b0;
            m_unf[i]  = 1'b0;
            m_dout[i] = 8'h00;
        end else begin
            racc = rdv && (occ > 0);
            wacc = wrv && ((occ < m_depth[i]) || racc);
            if (racc) begin
                m_dout[i] = hist[i][rcnt[i]];
                rcnt[i]++;
            end
            if (wacc) begin
                hist[i][wcnt[i]] = dv;
                wcnt[i]++;
            end
            if (wrv && !wacc) m_ovf[i] = 1'b1;
            else if (clrv)    m_ovf[i] = 1'b0;
            if (rdv && !racc) m_unf[i] = 1'b1;
            else if (clrv)    m_unf[i] = 1'b0;
        end
    endtask

    task automatic check_dut(input int i);
        int         occ;
        logic [7:0] exp_d;
        occ = wcnt[i] - rcnt[i];
        if (m_fwft[i] != 0) exp_d = (occ > 0) ? hist[i][rcnt[i]] : 8'h00;
        else                exp_d = m_dout[i];
        chk($sformatf("u%0d.count", i),        32'(cnt_w[i]), 32'(occ));
        chk($sformatf("u%0d.empty", i),        32'(emp_w[i]), 32'(occ == 0));
        chk($sformatf("u%0d.full", i),         32'(ful_w[i]), 32'(occ == m_depth[i]));
        chk($sformatf("u%0d.almost_empty", i), 32'(ae_w[i]),  32'(occ <= m_ae[i]));
        chk($sformatf("u%0d.almost_full", i),  32'(af_w[i]),  32'(occ >= m_af[i]));
        chk($sformatf("u%0d.overflow", i),     32'(ovf_w[i]), 32'(m_ovf[i]));
        chk($sformatf("u%0d.underflow", i),    32'(unf_w[i]), 32'(m_unf[i]));
        chk($sformatf("u%0d.data_out", i),     32'(dout_w[i]), 32'(exp_d));
    endtask

    // One clock: drive, let the edge happen, advance the model, sample #1 later.
    task automatic step(input logic rstv, input logic wrv, input logic rdv,
                        input logic clrv, input logic [7:0] dv);
        rst = rstv; wr = wrv; rd = rdv; err_clr = clrv; data_in = dv;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_update(i, rstv, wrv, rdv, clrv, dv);
        #1;
        for (int i = 0; i < 3; i++) check_dut(i);
    endtask

    initial begin
        int   bias;
        int   pw;
        int   pr;
        logic rw;
        logic rr;
        logic rc;
        logic rs;

        rst = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; data_in = 8'h00;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("reset.empty", 32'(emp_w[0]), 32'd1);
        chk("reset.dout", 32'(dout_w[0]), 32'd0);

        // Basic ordering, then overflow on u0
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h10);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h20);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h30);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h40);
        chk("basic.full", 32'(ful_w[0]), 32'd1);
        chk("basic.count", 32'(cnt_w[0]), 32'd4);
        chk("basic.af", 32'(af_w[0]), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h50);
        chk("ovf.set", 32'(ovf_w[0]), 32'd1);
        chk("ovf.count", 32'(cnt_w[0]), 32'd4);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("ovf.hold", 32'(ovf_w[0]), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("ovf.clr", 32'(ovf_w[0]), 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("basic.rd0", 32'(dout_w[0]), 32'h10);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("basic.rd3", 32'(dout_w[0]), 32'h40);
        chk("basic.empty_end", 32'(emp_w[0]), 32'd1);

        // Simultaneous rd/wr when empty
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'hAA);
        chk("unf.set", 32'(unf_w[0]), 32'd1);
        chk("unf.count", 32'(cnt_w[0]), 32'd1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("unf.data", 32'(dout_w[0]), 32'hAA);

        // Full simultaneous access with wrap on DEPTH=5
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 1; k <= 5; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'(k));
        for (int k = 6; k <= 8; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 8'(k));
            chk("wrap.count", 32'(cnt_w[1]), 32'd5);
            chk("wrap.dout", 32'(dout_w[1]), 32'(k - 5));
        end
        for (int k = 4; k <= 8; k++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
            chk("wrap.drain", 32'(dout_w[1]), 32'(k));
        end
        chk("wrap.no_ovf", 32'(ovf_w[1]), 32'd0);

        // FWFT head visibility and AE_LEVEL=1
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h11);
        chk("fwft.empty", 32'(emp_w[2]), 32'd0);
        chk("fwft.head", 32'(dout_w[2]), 32'h11);
        chk("fwft.ae1", 32'(ae_w[2]), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h12);
        chk("fwft.ae2", 32'(ae_w[2]), 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("fwft.pop", 32'(dout_w[2]), 32'h12);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("fwft.zero", 32'(dout_w[2]), 32'h00);

        // Reset mid-operation discards the concurrent write
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'hC0 + k));
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'hC5);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'hEE);
        chk("midrst.count", 32'(cnt_w[0]), 32'd0);
        chk("midrst.dout", 32'(dout_w[0]), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("midrst.discard", 32'(cnt_w[1]), 32'd0);

        // Randomised traffic with phases biased toward full, empty, balanced
        for (int n = 0; n < 400; n++) begin
            bias = (n / 50) % 3;
            pw = (bias == 0) ? 80 : ((bias == 1) ? 20 : 50);
            pr = (bias == 0) ? 25 : ((bias == 1) ? 80 : 50);
            rw = ($urandom_range(99) < pw);
            rr = ($urandom_range(99) < pr);
            rc = ($urandom_range(9) == 0);
            rs = ($urandom_range(59) != 0);
            step(rs, rw, rr, rc, 8'($urandom_range(255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
